text_console_ctrl: RTL

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: command-driven controller for a character-cell text
// buffer (COLS x ROWS cells, one byte per cell, row-major).
//
// Ports:
//   clk25, rst_n                single clock, synchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (ready only when idle)
//   cmd_op, cmd_data,
//   cmd_col, cmd_row            command code and operands, captured on accept
//   ram_addr/ram_we/ram_wdata   character-buffer write/read port
//   ram_rdata                   buffer read data, one cycle after the address
//   cursor_col, cursor_row      current cursor position
//   busy                        high whenever a command is in progress
module text_console_ctrl #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 60,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic [6:0]  cmd_col,
  input  logic [5:0]  cmd_row,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [12:0] CELLS_LAST = 13'(COLS * ROWS - 1);
  localparam logic [12:0] COPY_LAST  = 13'(COLS * (ROWS - 1) - 1);
  localparam logic [12:0] COLS_A     = 13'(COLS);
  localparam logic [6:0]  COL_MAX    = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX    = 6'(ROWS - 1);

  localparam logic [1:0] OP_PUTCHAR = 2'b00;
  localparam logic [1:0] OP_CLEAR   = 2'b01;
  localparam logic [1:0] OP_SETCUR  = 2'b10;
  localparam logic [1:0] OP_SCROLL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_CLEAR,
    S_SCROLL_RD,
    S_SCROLL_WR,
    S_SCROLL_BLANK
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  char_q, char_d;
  logic [12:0] cursor_addr;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
    end
  end

  assign cursor_addr = {7'd0, row_q} * COLS_A + {6'd0, col_q};
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    char_d    = char_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cmd_ready = 1'b0;
    busy      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          char_d = cmd_data;
          unique case (cmd_op)
            OP_PUTCHAR: begin
              // CR and LF are handled at acceptance; only LF on the last
              // row needs a following scroll.
              if (cmd_data == 8'h0D) begin
                col_d = '0;
              end else if (cmd_data == 8'h0A) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                  state_d = S_SCROLL_RD;
                  addr_d  = '0;
                end else begin
                  row_d = row_q + 6'd1;
                end
              end else begin
                state_d = S_PUT;
              end
            end
            OP_CLEAR: begin
              state_d = S_CLEAR;
              addr_d  = '0;
            end
            OP_SETCUR: begin
              col_d = (cmd_col > COL_MAX) ? COL_MAX : cmd_col;
              row_d = (cmd_row > ROW_MAX) ? ROW_MAX : cmd_row;
            end
            OP_SCROLL: begin
              state_d = S_SCROLL_RD;
              addr_d  = '0;
            end
            default: ;
          endcase
        end
      end

      S_PUT: begin
        ram_we    = 1'b1;
        ram_addr  = cursor_addr;
        ram_wdata = char_q;
        state_d   = S_IDLE;
        if (col_q == COL_MAX) begin
          col_d = '0;
          if (row_q == ROW_MAX) begin
            state_d = S_SCROLL_RD;
            addr_d  = '0;
          end else begin
            row_d = row_q + 6'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = BLANK;
        if (addr_q == CELLS_LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          addr_d = addr_q + 13'd1;
        end
      end

      // addr_q holds the destination cell; the source is one row below.
      S_SCROLL_RD: begin
        ram_addr = addr_q + COLS_A;
        state_d  = S_SCROLL_WR;
      end

      S_SCROLL_WR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = ram_rdata;
        addr_d    = addr_q + 13'd1;
        state_d   = (addr_q == COPY_LAST) ? S_SCROLL_BLANK : S_SCROLL_RD;
      end

      S_SCROLL_BLANK: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = BLANK;
        if (addr_q == CELLS_LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 13'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
